forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/forward_scoreboard.sv | 156 +++++++++++++++
 tb/tb_forward_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// Decode-stage operand forwarding select, load-use detection and a small
// long-latency-op scoreboard with timed writeback and a stall statistic.
package forward_scoreboard_pkg;
   typedef logic [4:0] reg_t;
endpackage

module forward_scoreboard
   import forward_scoreboard_pkg::*;
#(
   parameter int NREAD  = 2,
   parameter int NSTAGE = 2,
   parameter int NLOP   = 2,
   parameter int LATW   = 4,
   localparam int SELW  = $clog2(NSTAGE + 1)
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic [NREAD*5-1:0]      id_rsel,
   input  logic [NSTAGE*5-1:0]     stage_rd,
   input  logic [NSTAGE-1:0]       stage_wen,
   input  logic [NSTAGE-1:0]       stage_load,
   input  logic                    lop_issue,
   input  reg_t                    lop_rd,
   input  logic [LATW-1:0]         lop_lat,
   output logic [NREAD*SELW-1:0]   fwd_sel,
   output logic                    stall,
   output logic                    lop_ready,
   output logic                    lop_wb,
   output reg_t                    lop_wb_rd,
   output logic [15:0]             stall_cycles
);

   localparam int IDXW = (NLOP > 1) ? $clog2(NLOP) : 1;
   localparam logic [LATW-1:0] LAT_ONE = LATW'(1'b1);

   logic [NLOP-1:0]      valid_r;
   reg_t                 rd_r  [NLOP];
   logic [LATW-1:0]      cnt_r [NLOP];
   logic [15:0]          stall_cnt_r;

   logic [NREAD*SELW-1:0] fwd_sel_s;
   logic [NREAD-1:0]      load_use_s;
   logic                  sb_hit_s;
   logic                  wb_hit_s;
   logic [IDXW-1:0]       wb_idx_s;
   reg_t                  wb_rd_s;
   logic                  free_hit_s;
   logic [IDXW-1:0]       free_idx_s;
   logic                  alloc_s;
   logic [LATW-1:0]       lat_load_s;
   logic                  stall_s;

   // Forward select per read port: scanning from the oldest stage down lets the nearest match win.
   always_comb begin
      fwd_sel_s  = {(NREAD*SELW){1'b0}};
      load_use_s = {NREAD{1'b0}};
      for (int p = 0; p < NREAD; p++) begin
         for (int k = NSTAGE - 1; k >= 0; k--) begin
            if ((id_rsel[p*5 +: 5] != 5'd0) && stage_wen[k] &&
                (stage_rd[k*5 +: 5] == id_rsel[p*5 +: 5])) begin
               fwd_sel_s[p*SELW +: SELW] = SELW'(k + 1);
               load_use_s[p]             = stage_load[k];
            end else begin
               fwd_sel_s[p*SELW +: SELW] = fwd_sel_s[p*SELW +: SELW];
               load_use_s[p]             = load_use_s[p];
            end
         end
      end
   end

   // Scoreboard hazard: any valid entry, including one writing back now, blocks its rd.
   always_comb begin
      sb_hit_s = 1'b0;
      for (int p = 0; p < NREAD; p++) begin
         for (int e = 0; e < NLOP; e++) begin
            if (valid_r[e] && (id_rsel[p*5 +: 5] != 5'd0) && (rd_r[e] == id_rsel[p*5 +: 5])) begin
               sb_hit_s = 1'b1;
            end else begin
               sb_hit_s = sb_hit_s;
            end
         end
      end
   end

   // Lowest-index writeback winner and lowest-index free slot, both from current state.
   always_comb begin
      wb_hit_s   = 1'b0;
      wb_idx_s   = {IDXW{1'b0}};
      wb_rd_s    = 5'd0;
      free_hit_s = 1'b0;
      free_idx_s = {IDXW{1'b0}};
      for (int e = NLOP - 1; e >= 0; e--) begin
         if (valid_r[e] && (cnt_r[e] == LAT_ONE)) begin
            wb_hit_s = 1'b1;
            wb_idx_s = IDXW'(e);
            wb_rd_s  = rd_r[e];
         end else begin
            wb_hit_s = wb_hit_s;
         end
         if (!valid_r[e]) begin
            free_hit_s = 1'b1;
            free_idx_s = IDXW'(e);
         end else begin
            free_hit_s = free_hit_s;
         end
      end
   end

   assign alloc_s    = lop_issue && free_hit_s && (lop_rd != 5'd0);
   assign lat_load_s = (lop_lat == {LATW{1'b0}}) ? LAT_ONE : lop_lat;
   assign stall_s    = (|load_use_s) | sb_hit_s;

   // Scoreboard entries: allocate, retire on writeback, otherwise count down to 1 and hold.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_r <= {NLOP{1'b0}};
         for (int e = 0; e < NLOP; e++) begin
            rd_r[e]  <= 5'd0;
            cnt_r[e] <= {LATW{1'b0}};
         end
      end else begin
         for (int e = 0; e < NLOP; e++) begin
            if (alloc_s && (free_idx_s == IDXW'(e))) begin
               valid_r[e] <= 1'b1;
               rd_r[e]    <= lop_rd;
               cnt_r[e]   <= lat_load_s;
            end else if (wb_hit_s && (wb_idx_s == IDXW'(e))) begin
               valid_r[e] <= 1'b0;
            end else if (valid_r[e] && (cnt_r[e] > LAT_ONE)) begin
               cnt_r[e] <= cnt_r[e] - LAT_ONE;
            end else begin
               cnt_r[e] <= cnt_r[e];
            end
         end
      end
   end

   // Saturating count of cycles spent stalled.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_r <= 16'd0;
      end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign fwd_sel      = fwd_sel_s;
   assign stall        = stall_s;
   assign lop_ready    = free_hit_s;
   assign lop_wb       = wb_hit_s;
   assign lop_wb_rd    = wb_rd_s;
   assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed self-checking bench for forward_scoreboard with default parameters.
module tb_forward_scoreboard;

   logic        CLK;
   logic        nRST;
   logic [9:0]  id_rsel;
   logic [9:0]  stage_rd;
   logic [1:0]  stage_wen;
   logic [1:0]  stage_load;
   logic        lop_issue;
   logic [4:0]  lop_rd;
   logic [3:0]  lop_lat;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic        lop_ready;
   logic        lop_wb;
   logic [4:0]  lop_wb_rd;
   logic [15:0] stall_cycles;

   int n_assert = 0;
   int n_fail   = 0;

   forward_scoreboard dut (
      .CLK(CLK), .nRST(nRST), .id_rsel(id_rsel), .stage_rd(stage_rd),
      .stage_wen(stage_wen), .stage_load(stage_load), .lop_issue(lop_issue),
      .lop_rd(lop_rd), .lop_lat(lop_lat), .fwd_sel(fwd_sel), .stall(stall),
      .lop_ready(lop_ready), .lop_wb(lop_wb), .lop_wb_rd(lop_wb_rd),
      .stall_cycles(stall_cycles)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0; id_rsel = 10'd0; stage_rd = 10'd0; stage_wen = 2'b00;
      stage_load = 2'b00; lop_issue = 1'b0; lop_rd = 5'd0; lop_lat = 4'd0;
      #2;
      chk("rst_fwd_sel", fwd_sel, 4'd0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_ready", lop_ready, 1'b1);
      chk("rst_wb", lop_wb, 1'b0);
      chk("rst_wb_rd", lop_wb_rd, 5'd0);
      chk("rst_stall_cycles", stall_cycles, 16'd0);
      step(); step();
      nRST = 1'b1;
      step();

      // forwarding priority
      id_rsel = {5'd0, 5'd5}; stage_rd = {5'd5, 5'd5}; stage_wen = 2'b11; #1;
      chk("fwd_both_stages", fwd_sel, 4'b0001);
      chk("fwd_no_stall", stall, 1'b0);
      stage_wen = 2'b10; #1;
      chk("fwd_stage1_only", fwd_sel, 4'b0010);
      id_rsel = {5'd5, 5'd3}; stage_wen = 2'b11; #1;
      chk("fwd_port1", fwd_sel, 4'b0100);

      // load-use and x0
      id_rsel = {5'd7, 5'd0}; stage_rd = {5'd0, 5'd7}; stage_wen = 2'b01; stage_load = 2'b01; #1;
      chk("load_use_stall", stall, 1'b1);
      chk("load_use_fwd", fwd_sel, 4'b0100);
      step();
      chk("stall_cnt_1", stall_cycles, 16'd1);
      id_rsel = 10'd0; stage_rd = 10'd0; #1;
      chk("x0_no_stall", stall, 1'b0);
      chk("x0_no_fwd", fwd_sel, 4'd0);
      step();
      chk("stall_cnt_hold", stall_cycles, 16'd1);
      stage_wen = 2'b00; stage_load = 2'b00;

      // single long op rd=9 lat=3
      id_rsel = {5'd0, 5'd9}; lop_issue = 1'b1; lop_rd = 5'd9; lop_lat = 4'd3; #1;
      chk("lop_c0_stall", stall, 1'b0);
      chk("lop_c0_ready", lop_ready, 1'b1);
      step(); lop_issue = 1'b0; #1;
      chk("lop_c1_stall", stall, 1'b1);
      chk("lop_c1_wb", lop_wb, 1'b0);
      step();
      chk("lop_c2_stall", stall, 1'b1);
      chk("lop_c2_wb", lop_wb, 1'b0);
      step();
      chk("lop_c3_stall", stall, 1'b1);
      chk("lop_c3_wb", lop_wb, 1'b1);
      chk("lop_c3_wb_rd", lop_wb_rd, 5'd9);
      step();
      chk("lop_c4_stall", stall, 1'b0);
      chk("lop_c4_wb", lop_wb, 1'b0);
      chk("lop_c4_wb_rd", lop_wb_rd, 5'd0);
      chk("stall_cnt_4", stall_cycles, 16'd4);

      // fill both entries, simultaneous countdown
      id_rsel = 10'd0; lop_issue = 1'b1; lop_rd = 5'd3; lop_lat = 4'd2; #1;
      step();
      lop_rd = 5'd4; lop_lat = 4'd1; #1;
      chk("fill_ready_b", lop_ready, 1'b1);
      step();
      lop_rd = 5'd6; lop_lat = 4'd5; #1;
      chk("full_ready", lop_ready, 1'b0);
      chk("full_wb0", lop_wb, 1'b1);
      chk("full_wb0_rd", lop_wb_rd, 5'd3);
      step();
      lop_issue = 1'b0; #1;
      chk("wb1_pulse", lop_wb, 1'b1);
      chk("wb1_rd", lop_wb_rd, 5'd4);
      chk("wb1_ready", lop_ready, 1'b1);
      step();
      id_rsel = {5'd4, 5'd6}; #1;
      chk("third_ignored", stall, 1'b0);
      chk("drained_wb", lop_wb, 1'b0);
      id_rsel = 10'd0;

      // lat=0 treated as 1
      lop_issue = 1'b1; lop_rd = 5'd10; lop_lat = 4'd0; #1;
      step();
      lop_issue = 1'b0; #1;
      chk("lat0_wb", lop_wb, 1'b1);
      chk("lat0_wb_rd", lop_wb_rd, 5'd10);
      step();
      chk("lat0_done", lop_wb, 1'b0);
      chk("lat0_ready", lop_ready, 1'b1);

      // rd=0 does not allocate
      lop_issue = 1'b1; lop_rd = 5'd0; lop_lat = 4'd3; #1;
      step();
      chk("rd0_ready", lop_ready, 1'b1);
      lop_rd = 5'd11; lop_lat = 4'd8; #1;
      step();
      chk("rd0_one_used", lop_ready, 1'b1);
      lop_rd = 5'd12; #1;
      step();
      lop_issue = 1'b0; #1;
      chk("two_used_ready", lop_ready, 1'b0);

      // reset mid-operation
      id_rsel = {5'd12, 5'd11}; #1;
      chk("pre_rst_stall", stall, 1'b1);
      step();
      chk("stall_cnt_5", stall_cycles, 16'd5);
      nRST = 1'b0; #1;
      chk("mid_rst_ready", lop_ready, 1'b1);
      chk("mid_rst_stall", stall, 1'b0);
      chk("mid_rst_wb", lop_wb, 1'b0);
      chk("mid_rst_stall_cycles", stall_cycles, 16'd0);
      step(); step();
      nRST = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("post_rst_wb", lop_wb, 1'b0);
         chk("post_rst_stall", stall, 1'b0);
         step();
      end

      // saturation of stall_cycles
      id_rsel = {5'd7, 5'd0}; stage_rd = {5'd0, 5'd7}; stage_wen = 2'b01; stage_load = 2'b01; #1;
      chk("sat_start", stall_cycles, 16'd0);
      for (int i = 0; i < 65534; i++) step();
      chk("sat_fffe", stall_cycles, 16'hFFFE);
      step();
      chk("sat_ffff", stall_cycles, 16'hFFFF);
      for (int i = 0; i < 5; i++) step();
      chk("sat_hold", stall_cycles, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
